// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage: the canonical NOP
// driven to the decoder when the buffer is empty, the fetch FSM state
// encodings, the default reset PC and a PC alignment helper.
// No ports (package).
package fetch_unit_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bundles the fetch stage's external handshakes:
//   memory side : mem_req/mem_addr out, mem_ack/mem_rdata in
//   execute side: redirect/redirect_pc in
//   decoder side: instr/instr_pc/instr_valid out, instr_ready in
// master = fetch unit, slave = the surrounding memory/decoder/execute logic.
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo
// DEPTH-entry FIFO of {pc, instr} pairs between instruction memory and the
// decoder.  flush empties the FIFO and wins over push/pop in the same cycle.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data at the tail
//   push_data   : {pc[31:0], instr[31:0]}
//   pop         : drop the head entry (caller guarantees non-empty)
//   flush       : discard all entries
//   count       : number of valid entries (0..DEPTH)
//   head        : head entry; contents undefined when count==0
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [63:0]                  push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [63:0]                  head
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: owns the fetch PC, issues one word read at a time
// to instruction memory, buffers returned words with their PCs and hands them
// to the decoder.  A redirect flushes the buffer and discards any in-flight
// read.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_unit_if.master (memory, redirect and decoder handshakes)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no read outstanding; issue when the buffer has space
// ST_WAIT | read to mem_addr outstanding; its data will be buffered
// ST_DROP | read outstanding but stale after a redirect; data discarded
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t     state, state_next;
  logic [31:0]      fetch_pc, fetch_pc_next;
  logic [31:0]      mem_addr_q, mem_addr_next;
  logic             mem_req_q, mem_req_next;
  logic [31:0]      redirect_addr, pc_plus4;
  logic             push, pop, empty;
  logic [CNT_W-1:0] count, count_next;
  logic [63:0]      head;

  assign redirect_addr = word_align(bus.redirect_pc);
  assign pc_plus4      = fetch_pc + 32'd4;

  assign empty = (count == '0);
  assign pop   = !empty && bus.instr_ready;
  // A word returning together with a redirect is stale and never buffered.
  assign push  = (state == ST_WAIT) && bus.mem_ack && !bus.redirect;
  // Occupancy after this edge; decides whether the next read goes back-to-back.
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_pc, bus.mem_rdata}),
    .pop       (pop),
    .flush     (bus.redirect),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fetch_pc   <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      mem_req_q  <= mem_req_next;
      mem_addr_q <= mem_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    mem_req_next  = mem_req_q;
    mem_addr_next = mem_addr_q;

    case (state)
      ST_IDLE: begin
        if (bus.redirect) begin
          // New PC is issued on the following edge.
          fetch_pc_next = redirect_addr;
        end else if (count < DEPTH_C) begin
          mem_req_next  = 1'b1;
          mem_addr_next = fetch_pc;
          state_next    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.redirect) begin
          fetch_pc_next = redirect_addr;
          if (bus.mem_ack) begin
            mem_req_next = 1'b0;
            state_next   = ST_IDLE;
          end else begin
            // The old read cannot be withdrawn; ride it out and drop its data.
            state_next = ST_DROP;
          end
        end else if (bus.mem_ack) begin
          fetch_pc_next = pc_plus4;
          if (count_next < DEPTH_C) begin
            mem_addr_next = pc_plus4;
          end else begin
            mem_req_next = 1'b0;
            state_next   = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        if (bus.redirect) begin
          fetch_pc_next = redirect_addr;
        end
        if (bus.mem_ack) begin
          mem_req_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  // Empty buffer presents a NOP at PC 0 so the decoder never sees stale data.
  assign bus.instr_valid = !empty;
  assign bus.instr       = empty ? NOP_INSTR : head[31:0];
  assign bus.instr_pc    = empty ? 32'h0000_0000 : head[63:32];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit (DEPTH=4).  Memory returns addr^A5A5_0000
// unless overridden.  A per-cycle vector table covers zero-wait streaming,
// stall/drain and resume; hand-written sequences cover delayed ack,
// redirects, PC wrap and reset mid-transfer.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        ovr_en;
  logic [31:0] ovr_data;

  fetch_unit_if bus();

  assign bus.mem_rdata = ovr_en ? ovr_data : (bus.mem_addr ^ 32'hA5A5_0000);

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ack;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] ins, input logic [31:0] pc);
    chk({name, " mem_req"},     32'(bus.mem_req),     32'(req));
    chk({name, " mem_addr"},    bus.mem_addr,         addr);
    chk({name, " instr_valid"}, 32'(bus.instr_valid), 32'(valid));
    chk({name, " instr"},       bus.instr,            ins);
    chk({name, " instr_pc"},    bus.instr_pc,         pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst             = 1'b1;
    bus.mem_ack     = 1'b0;
    bus.redirect    = 1'b0;
    bus.instr_ready = ready;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ack, ready | req, addr, valid, instr, pc   (outputs seen in that cycle)
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, NOP_INSTR,    32'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, NOP_INSTR,    32'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'hA5A50000, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'hA5A50004, 32'h04};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'hA5A50008, 32'h08};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'hA5A5000C, 32'h0C};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'hA5A5000C, 32'h0C};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'hA5A5000C, 32'h0C};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h18, 1'b1, 32'hA5A5000C, 32'h0C};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h18, 1'b1, 32'hA5A5000C, 32'h0C};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 32'hA5A5000C, 32'h0C};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h18, 1'b1, 32'hA5A50010, 32'h10};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'hA5A50010, 32'h10};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'hA5A50014, 32'h14};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'hA5A50018, 32'h18};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'hA5A5001C, 32'h1C};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b0, NOP_INSTR,    32'h00};

    rst             = 1'b1;
    bus.mem_ack     = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    ovr_en          = 1'b0;
    ovr_data        = 32'h0;
    step();
    step();
    check_out("reset", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
    rst = 1'b0;

    // Streaming, stall to full, drain and resume.
    for (int i = 0; i < 17; i++) begin
      bus.mem_ack     = vecs[i].ack;
      bus.instr_ready = vecs[i].ready;
      check_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
      step();
    end
    bus.mem_ack = 1'b0;

    // Ack delayed three cycles.
    do_reset(1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dly%0d mem_req", k),     32'(bus.mem_req),     32'd1);
      chk($sformatf("dly%0d mem_addr", k),    bus.mem_addr,         32'h0);
      chk($sformatf("dly%0d instr_valid", k), 32'(bus.instr_valid), 32'd0);
      step();
    end
    bus.mem_ack = 1'b1;
    chk("dly ack-cycle instr_valid", 32'(bus.instr_valid), 32'd0);
    step();
    bus.mem_ack = 1'b0;
    check_out("dly after-ack", 1'b1, 32'h4, 1'b1, 32'hA5A50000, 32'h0);

    // Redirect to 0x100 while a read is outstanding; its data is dropped.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    check_out("rdw drop0", 1'b1, 32'h4, 1'b0, NOP_INSTR, 32'h0);
    step();
    check_out("rdw drop1", 1'b1, 32'h4, 1'b0, NOP_INSTR, 32'h0);
    bus.mem_ack = 1'b1;
    ovr_en      = 1'b1;
    ovr_data    = 32'hDEADBEEF;
    chk("rdw ack-cycle instr", bus.instr, NOP_INSTR);
    step();
    bus.mem_ack = 1'b0;
    ovr_en      = 1'b0;
    check_out("rdw dropped", 1'b0, 32'h4, 1'b0, NOP_INSTR, 32'h0);
    step();
    check_out("rdw newreq", 1'b1, 32'h100, 1'b0, NOP_INSTR, 32'h0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check_out("rdw first", 1'b1, 32'h104, 1'b1, 32'hA5A50100, 32'h100);

    // Redirect to 0x203 coinciding with an ack, two words buffered.
    do_reset(1'b0);
    step();
    bus.mem_ack = 1'b1;
    step();
    step();
    check_out("rda full2", 1'b1, 32'h8, 1'b1, 32'hA5A50000, 32'h0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h203;
    step();
    bus.redirect = 1'b0;
    bus.mem_ack  = 1'b0;
    check_out("rda flushed", 1'b0, 32'h8, 1'b0, NOP_INSTR, 32'h0);
    step();
    check_out("rda newreq", 1'b1, 32'h200, 1'b0, NOP_INSTR, 32'h0);
    bus.instr_ready = 1'b1;
    bus.mem_ack     = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check_out("rda first", 1'b1, 32'h204, 1'b1, 32'hA5A50200, 32'h200);

    // Redirect to the top word; fetch wraps to 0.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    check_out("wrap drop", 1'b1, 32'h204, 1'b0, NOP_INSTR, 32'h0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check_out("wrap idle", 1'b0, 32'h204, 1'b0, NOP_INSTR, 32'h0);
    step();
    check_out("wrap req", 1'b1, 32'hFFFF_FFFC, 1'b0, NOP_INSTR, 32'h0);
    bus.mem_ack = 1'b1;
    step();
    check_out("wrap top", 1'b1, 32'h0, 1'b1, 32'h5A5AFFFC, 32'hFFFF_FFFC);
    step();
    bus.mem_ack = 1'b0;
    check_out("wrap zero", 1'b1, 32'h4, 1'b1, 32'hA5A50000, 32'h0);

    // Reset while a read is outstanding; a stray ack afterwards is ignored.
    rst = 1'b1;
    step();
    check_out("rstw", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
    rst         = 1'b0;
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check_out("rstw restart", 1'b1, 32'h0, 1'b0, NOP_INSTR, 32'h0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check_out("rstw first", 1'b1, 32'h4, 1'b1, 32'hA5A50000, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the 32-bit instruction stream consumed by the RV32I decoder. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned words go into a small buffer, and each word is presented to the decoder with its PC over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard any in-flight read.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0
- DEPTH, 2, instruction buffer entries, power of two, ≥2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  read request, registered
- mem_addr  out  32  word address, registered, stable while mem_req high
- mem_ack  in  1  one-cycle response strobe, valid only while mem_req high
- mem_rdata  in  32  read data, valid with mem_ack
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] ignored, treated as 0
- instr  out  32  buffer-head instruction word to decoder
- instr_pc  out  32  PC of instr
- instr_valid  out  1  buffer non-empty
- instr_ready  in  1  decoder accepts head this cycle

## Operation
- Internal state: fetch_pc (32), buffer count (0..DEPTH), FSM {IDLE, WAIT, DROP}.
- Reset values: mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, count=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, state=IDLE.
- Empty buffer always drives instr=NOP and instr_pc=0, so the combinational decoder never sees X or undefined opcodes.
- IDLE: if count<DEPTH, then next cycle mem_req=1, mem_addr=fetch_pc, state=WAIT.
- WAIT, mem_ack=1:
  - Push {fetch_pc, mem_rdata}; fetch_pc+=4, wrapping modulo 2^32 (0xFFFF_FFFC → 0).
  - If count_next<DEPTH, mem_req stays 1 with mem_addr=new fetch_pc (back-to-back); otherwise mem_req=0 and state=IDLE.
  - count_next is count after this cycle's push and pop.
- WAIT, no ack: hold mem_req and mem_addr unchanged. The request is never withdrawn except by rst.
- Pop: instr_valid && instr_ready at an edge removes the head. Push and pop in the same cycle leave count unchanged. Push when count==DEPTH cannot occur, because issue is gated by space.
- redirect (highest priority, takes effect at the edge where it is sampled):
  - Buffer cleared (count=0), fetch_pc=redirect_pc&~3. A pop in the same cycle is irrelevant.
  - IDLE: next state IDLE, and a request to the new PC follows on the next edge.
  - WAIT without ack: state=DROP. mem_req and old mem_addr are held until ack, and that ack's data is discarded.
  - WAIT with ack in the same cycle: the data is discarded, mem_req=0, state=IDLE.
  - DROP: fetch_pc updated again, stay DROP.
- DROP, mem_ack=1: discard data, mem_req=0, state=IDLE.
- Only one request is outstanding at a time.

## Timing
- Reset deasserted at edge E0 → mem_req=1, mem_addr=RESET_PC after edge E1.
- Ack sampled at edge N → instr_valid=1 with that word after edge N; the decoder sees it in cycle N+1.
- With zero-wait memory (ack in the same cycle as req) and the decoder always ready, sustained throughput is 1 instruction/cycle.
- Redirect sampled at edge R:
  - instr_valid=0 from R on.
  - If no old read is pending, the first new-PC request is asserted after edge R+1.
  - In DROP, the new-PC request is asserted one edge after the dropped ack.
- rst mid-transfer: all state returns to reset values at that edge and any later ack for the abandoned request is ignored (mem_req=0). The memory side must tolerate request withdrawal on reset.

## Structure
- Shared header (alongside opcode definitions):
  - `NOP_INSTR 32'h0000_0013`
  - FSM state encodings for IDLE/WAIT/DROP
  - default RESET_PC
- Sub-module fetch_fifo:
  - DEPTH-entry FIFO of 64-bit {pc, instr} entries.
  - Ports: push, pop, flush, count, head.
  - flush has priority over push/pop.
- fetch_unit holds the PC, the FSM and the NOP/empty output muxing.

## Test plan
- Reset, zero-wait memory returning addr^32'hA5A5_0000, decoder always ready → mem_addr 0,4,8,… on consecutive cycles; instr/instr_pc pairs match in order, instr_valid continuous from cycle 2.
- Decoder stalled (instr_ready=0) → exactly DEPTH words buffered, then mem_req=0. Releasing ready drains them in order and resumes at the next PC.
- Ack delayed 3 cycles → mem_req and mem_addr=0x0 stable for 3 cycles, instr_valid low until the cycle after the ack.
- Redirect to 0x100 while waiting (ack 2 cycles later with 0xDEADBEEF) → 0xDEADBEEF never appears; the next request is for 0x100 and the buffer is empty in between.
- Redirect to 0x203 in the same cycle as an ack, with the buffer holding 2 words → all discarded, the next request is for 0x200, and the first delivered instr_pc is 0x200.
- redirect_pc=0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000. Asserting rst mid-WAIT → mem_req=0 and instr=NOP, and fetch restarts at RESET_PC.
